// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_pkg
//  Description : Shared constants and types for the CHIP-8 execute-stage
//                helpers (BCD loader state encoding, decimal constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

  localparam int ADDR_W   = 12;
  localparam int DEC_BASE = 10;
  localparam int BYTE_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } bcd_load_state_t;

endpackage : chip8_pkg
`default_nettype wire

// File: rtl/bcd_digit_mac.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_mac
//  Description : One decimal accumulate step: acc_out = acc_in*10 + digit.
//                Bytes above 9 are clamped to 9 and flagged as invalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_mac
  import chip8_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [9:0]        acc_in_i,
  input  logic [DATA_W-1:0] byte_i,
  output logic [9:0]        acc_out_o,
  output logic              invalid_o
);

  logic [3:0] w_digit;

  // Clamp the digit and form the next accumulator value.
  always_comb begin
    invalid_o = (byte_i > DATA_W'(9));
    w_digit   = invalid_o ? 4'd9 : byte_i[3:0];
    // acc_in never exceeds 99 when a digit follows, so 10 bits never wrap.
    acc_out_o = (acc_in_i * 10'(DEC_BASE)) + {6'd0, w_digit};
  end

endmodule : bcd_digit_mac
`default_nettype wire

// File: rtl/bcd_load.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_load
//  Description : Multi-cycle BCD-to-binary loader. Reads hundreds, tens and
//                ones digit bytes from consecutive addresses, accumulates
//                them into a saturating 8-bit value and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_load
  import chip8_pkg::*;
#(
  parameter int ADDR_W = chip8_pkg::ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        value_o,
  output logic              overflow_o,
  output logic              bad_digit_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  bcd_load_state_t   state_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        idx_q;
  logic [9:0]        acc_q;
  logic              bad_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        value_q;
  logic              overflow_q;
  logic              bad_digit_q;

  logic [9:0]        w_acc_next;
  logic              w_invalid;

  bcd_digit_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .acc_in_i  (acc_q),
    .byte_i    (mem_rdata_i),
    .acc_out_o (w_acc_next),
    .invalid_o (w_invalid)
  );

  // Read strobe and address decode from state/index only.
  always_comb begin
    mem_rd_o   = (state_q == READ);
    mem_addr_o = mem_rd_o ? (base_q + ADDR_W'(idx_q)) : '0;
  end

  // Sequencer: issue three reads, accumulate returning digits, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= 2'd0;
      acc_q       <= 10'd0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= 8'd0;
      overflow_q  <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q      <= addr_i;
            idx_q       <= 2'd0;
            acc_q       <= 10'd0;
            bad_q       <= 1'b0;
            value_q     <= 8'd0;
            overflow_q  <= 1'b0;
            bad_digit_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          // Data returning now belongs to the read issued last cycle.
          if (idx_q != 2'd0) begin
            acc_q <= w_acc_next;
            bad_q <= bad_q | w_invalid;
          end
          if (idx_q == 2'd2) begin
            state_q <= LAST;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        LAST: begin
          acc_q       <= w_acc_next;
          bad_q       <= bad_q | w_invalid;
          overflow_q  <= (w_acc_next > 10'(BYTE_MAX));
          value_q     <= (w_acc_next > 10'(BYTE_MAX)) ? 8'(BYTE_MAX) : w_acc_next[7:0];
          bad_digit_q <= bad_q | w_invalid;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign value_o     = value_q;
  assign overflow_o  = overflow_q;
  assign bad_digit_o = bad_digit_q;

endmodule : bcd_load
`default_nettype wire

// File: tb/tb_bcd_load.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_load
//  Description : Self-checking bench for bcd_load with a synchronous memory
//                model and a decimal reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_load;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [11:0] addr_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  value_o;
  logic        overflow_o;
  logic        bad_digit_o;
  logic        mem_rd_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;

  logic [7:0]  mem [0:4095];
  int          n_checks;
  int          n_errors;
  int          done_cnt;

  bcd_load #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .value_o     (value_o),
    .overflow_o  (overflow_o),
    .bad_digit_o (bad_digit_o),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; garbage on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
    else          mem_rdata_i <= 8'($urandom);
  end

  always @(posedge clk) begin
    if (rst) done_cnt <= done_cnt;
    else if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: clamp digits, combine decimally, saturate.
  function automatic int dig(input logic [7:0] b);
    return (b > 8'd9) ? 9 : int'(b);
  endfunction

  task automatic run_op(input logic [11:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input bit pulse_mid, input bit pulse_done);
    int dec, exp_val, exp_ov, exp_bad, cnt0;
    logic [11:0] a1, a2;
    a1 = base + 12'd1;
    a2 = base + 12'd2;
    mem[base] = b0; mem[a1] = b1; mem[a2] = b2;
    dec     = dig(b0) * 100 + dig(b1) * 10 + dig(b2);
    exp_ov  = (dec > 255) ? 1 : 0;
    exp_val = exp_ov ? 255 : dec;
    exp_bad = (b0 > 9 || b1 > 9 || b2 > 9) ? 1 : 0;
    cnt0    = done_cnt;
    @(negedge clk); start_i = 1'b1; addr_i = base;
    @(negedge clk); start_i = 1'b0; addr_i = 12'($urandom);      // S+1
    chk("busy_s1", busy_o, 1);
    chk("rd_s1", mem_rd_o, 1);
    chk("addr_s1", mem_addr_o, base);
    chk("done_s1", done_o, 0);
    @(negedge clk);                                              // S+2
    chk("addr_s2", mem_addr_o, a1);
    if (pulse_mid) start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;                              // S+3
    chk("addr_s3", mem_addr_o, a2);
    @(negedge clk);                                              // S+4
    chk("rd_s4", mem_rd_o, 0);
    chk("maddr_s4", mem_addr_o, 0);
    chk("done_s4", done_o, 0);
    @(negedge clk);                                              // S+5
    chk("done_s5", done_o, 1);
    chk("busy_s5", busy_o, 1);
    chk("value", value_o, exp_val);
    chk("overflow", overflow_o, exp_ov);
    chk("bad_digit", bad_digit_o, exp_bad);
    if (pulse_done) start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;                              // S+6
    chk("busy_s6", busy_o, 0);
    chk("done_s6", done_o, 0);
    chk("value_held", value_o, exp_val);
    chk("done_count", done_cnt - cnt0, 1);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    int cnt0;
    n_checks = 0; n_errors = 0; done_cnt = 0;
    start_i = 1'b0; addr_i = 12'd0; rst = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    start_i = 1'b1;                       // rst wins over start
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_value", value_o, 0);
    chk("rst_ov", overflow_o, 0);
    chk("rst_bad", bad_digit_o, 0);
    chk("rst_rd", mem_rd_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    start_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_o, 0);

    // Directed cases
    run_op(12'h300, 8'd2, 8'd5, 8'd5, 1'b0, 1'b0);
    run_op(12'h300, 8'd2, 8'd5, 8'd6, 1'b0, 1'b0);
    run_op(12'h310, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0);
    run_op(12'h320, 8'd0, 8'd0, 8'd7, 1'b0, 1'b0);
    run_op(12'h330, 8'd1, 8'h0C, 8'd3, 1'b0, 1'b0);
    run_op(12'h340, 8'd0, 8'd4, 8'd2, 1'b0, 1'b0);
    run_op(12'hFFE, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
    run_op(12'h350, 8'd1, 8'd7, 8'd4, 1'b1, 1'b1);

    // Reset mid-operation at S+3
    cnt0 = done_cnt;
    mem[12'h400] = 8'd1; mem[12'h401] = 8'd2; mem[12'h402] = 8'd3;
    @(negedge clk); start_i = 1'b1; addr_i = 12'h400;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_rd", mem_rd_o, 0);
    chk("abort_value", value_o, 0);
    chk("abort_done", done_o, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - cnt0, 0);
    chk("abort_idle", busy_o, 0);

    // Randomized operations, including invalid bytes and stray starts
    for (int n = 0; n < 40; n++) begin
      r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      r2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      run_op(12'($urandom), r0, r1, r2, 1'($urandom), 1'($urandom));
    end

    // Exhaustive round trip of the digit split
    for (int v = 0; v < 256; v++) begin
      run_op(12'($urandom), 8'(v / 100), 8'((v / 10) % 10), 8'(v % 10), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bcd_load
`default_nettype wire

// File: doc/bcd_load.md
# bcd_load

Multi-cycle BCD-to-binary loader: reads three consecutive BCD digit bytes (hundreds, tens, ones) from CHIP-8 memory starting at a given address. It reassembles them into an 8-bit binary value. It is the inverse of the FX33 digit-split path, and it sits beside the memory port in the execute stage. It issues its own synchronous reads and reports completion with a one-cycle pulse.

## Interface
- ADDR_W, 12, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory data width; the digit value is taken from the full byte.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- addr  in  ADDR_W  base address of the hundreds digit; sampled on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; value/overflow/bad_digit are valid in this cycle.
- value  out  8  result; saturates to 255; held until the next accept or reset.
- overflow  out  1  decimal result exceeded 255; held like value.
- bad_digit  out  1  at least one byte was greater than 9; held like value.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_W  read address; driven 0 when mem_rd=0.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd.

## Operation
- FSM states: IDLE, READ, LAST, DONE.
- IDLE:
  - start=1 latches addr into base, clears idx, acc, bad and the held outputs, then goes to READ.
  - start=0 stays in IDLE.
- READ (idx = 0, 1, 2):
  - mem_rd=1, mem_addr = base+idx, wrapping at 2^ADDR_W.
  - If idx>0, accumulate mem_rdata (digit idx-1).
  - idx=2 goes to LAST; otherwise idx increments.
- LAST: mem_rd=0; accumulate mem_rdata (ones digit); register the outputs; go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE and in all non-IDLE states; it is not queued.
- Accumulate step: acc ← acc*10 + d.
  - d = mem_rdata if mem_rdata ≤ 9, else d = 9 and bad is set (sticky for the operation).
  - acc is 10 bits; the maximum is 999, so there is no internal wrap.
- Output rule:
  - overflow = (acc > 255).
  - value = overflow ? 255 : acc[7:0].
  - bad_digit = bad.
- Reset, including mid-operation:
  - Next state is IDLE.
  - busy, done, mem_rd, value, overflow, bad_digit, acc, idx and base all go to 0.
  - The operation in flight is aborted and no done is produced.
- start and rst in the same cycle: rst wins.

## Timing
- Accept at cycle S, meaning IDLE and start=1 sampled at the edge ending S.
- Cycle by cycle after accept:
  - S+1: READ0, mem_addr=base.
  - S+2: READ1, mem_addr=base+1.
  - S+3: READ2, mem_addr=base+2.
  - S+4: LAST.
  - S+5: DONE, done=1.
  - S+6: IDLE; the earliest possible next accept is cycle S+6.
- Fixed latency of 5 cycles from accept to done, with no stalls.
- busy rises in S+1 and falls in S+6.
- Memory is assumed single-cycle synchronous read with no wait states: data for the address issued in cycle k is sampled at the end of k+1.
- All outputs are registered except mem_addr and mem_rd, which decode from state/idx. No combinational path from inputs to outputs.

## Structure
- Shared package chip8_pkg holds:
  - ADDR_W default constant.
  - bcd_load_state_t enum {IDLE, READ, LAST, DONE}.
  - Constants DEC_BASE=10 and BYTE_MAX=255.
- Sub-module bcd_digit_mac is combinational. It takes acc_in[9:0] and byte[7:0] and returns acc_out[9:0] and invalid, applying the ×10, clamp and add. It is instantiated once in bcd_load.

## Test plan
- Memory [0x300]=2, [0x301]=5, [0x302]=5; start with addr=0x300 → mem_addr sequence 0x300/0x301/0x302 in S+1..S+3; done at S+5 with value=255, overflow=0, bad_digit=0.
- Bytes 2,5,6 → value=255, overflow=1. Bytes 9,9,9 → value=255, overflow=1. Bytes 0,0,7 → value=7, overflow=0.
- Bytes 1,0x0C,3 → bad_digit=1, decimal 193 → value=193. The following run with bytes 0,4,2 → value=42, bad_digit=0 (cleared on accept).
- Base addr=0xFFE → reads issued at 0xFFE, 0xFFF, 0x000; value assembled in that order.
- Assert rst in S+3 → busy=0 and mem_rd=0 next cycle, no done pulse, value=0. Pulsing start during S+2 and during DONE of a normal run → ignored, exactly one done.
- Exhaustive round trip: for every v in 0..255, preload the digit split of v → value=v, overflow=0, bad_digit=0.
